// File: rtl/float_to_fixed.sv
// float_to_fixed
//   Two-stage pipeline that converts an IEEE-754 single-precision operand
//   into a signed-magnitude fixed-point value with 1 integer bit and
//   WORD_LENGTH-2 fractional bits, for the downstream CORDIC stage.
//   Magnitudes of 2.0 and above (and infinities) are clamped to the largest
//   representable magnitude. NaN produces zero with a flag. Zero and
//   subnormal operands flush to zero.
//
// Ports
//   clk          : sole clock, rising edge
//   rst          : asynchronous reset, active low
//   valid_i      : float_i holds an operand
//   ready_o      : operand accepted this cycle when valid_i is also high
//   float_i      : IEEE-754 single-precision operand
//   valid_o      : result outputs hold a valid result
//   ready_i      : downstream accepts the result this cycle
//   sign_o       : result sign (1 = negative; never set for zero magnitude)
//   integer_o    : integer bit of the magnitude
//   fractional_o : fractional bits of the magnitude, MSB weight 2^-1
//   sat_o        : result was clamped to maximum magnitude
//   nan_o        : operand was NaN
module float_to_fixed #(
   parameter int WORD_LENGTH = 21
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [31:0]            float_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   sign_o,
   output logic                   integer_o,
   output logic [WORD_LENGTH-3:0] fractional_o,
   output logic                   sat_o,
   output logic                   nan_o
);

   // Magnitude width: integer bit plus fractional bits.
   localparam int MW = WORD_LENGTH - 1;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_SAT,
      CLS_NAN
   } cls_t;

   logic        v1, v2;
   logic        en1, en2;

   logic        s1_sign;
   cls_t        s1_cls;
   logic [7:0]  s1_sh;
   logic [23:0] s1_mant;

   cls_t        d_cls;
   logic [7:0]  d_sh;
   logic [7:0]  d_exp;
   logic [22:0] d_man;

   logic [MW-1:0] r_mag;
   logic          r_sign;
   logic          r_sat;
   logic          r_nan;

   // Stage 2 advances when empty or drained; stage 1 when stage 2 makes room.
   assign en2     = !v2 || ready_i;
   assign en1     = !v1 || en2;
   assign ready_o = en1;
   assign valid_o = v2;

   // Stage 1 decode
   assign d_exp = float_i[30:23];
   assign d_man = float_i[22:0];

   always_comb begin
      d_cls = CLS_NORM;
      d_sh  = 8'd127 - d_exp;
      if (d_exp == 8'd0) begin
         d_cls = CLS_ZERO;
      end else if (d_exp == 8'hFF && d_man != 23'd0) begin
         d_cls = CLS_NAN;
      end else if (d_exp[7]) begin
         d_cls = CLS_SAT;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1      <= 1'b0;
         s1_sign <= 1'b0;
         s1_cls  <= CLS_ZERO;
         s1_sh   <= '0;
         s1_mant <= '0;
      end else if (en1) begin
         v1 <= valid_i;
         if (valid_i) begin
            s1_sign <= float_i[31];
            s1_cls  <= d_cls;
            s1_sh   <= d_sh;
            s1_mant <= {1'b1, d_man};
         end
      end
   end

   // Stage 2 shift and classification.
   // Shifting by the extra (24-MW) positions lands the top MW bits of the
   // aligned mantissa in the low bits, so the cast truncates toward zero.
   // Any sh >= MW pushes the leading one out entirely, giving zero.
   always_comb begin
      r_mag  = '0;
      r_sign = s1_sign;
      r_sat  = 1'b0;
      r_nan  = 1'b0;
      unique case (s1_cls)
         CLS_NORM: r_mag = MW'(s1_mant >> (8'(24 - MW) + s1_sh));
         CLS_SAT: begin
            r_mag = '1;
            r_sat = 1'b1;
         end
         CLS_NAN:  r_nan = 1'b1;
         default:  r_mag = '0;
      endcase
      if (r_mag == '0) begin
         r_sign = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v2           <= 1'b0;
         sign_o       <= 1'b0;
         integer_o    <= 1'b0;
         fractional_o <= '0;
         sat_o        <= 1'b0;
         nan_o        <= 1'b0;
      end else if (en2) begin
         v2 <= v1;
         if (v1) begin
            sign_o                    <= r_sign;
            {integer_o, fractional_o} <= r_mag;
            sat_o                     <= r_sat;
            nan_o                     <= r_nan;
         end
      end
   end

endmodule

// File: tb/tb_float_to_fixed.sv
// tb_float_to_fixed
//   Self-checking bench for float_to_fixed: a table of operands with
//   hand-derived results driven through a scoreboard queue, plus directed
//   sequences for latency, backpressure and mid-flight reset.
module tb_float_to_fixed;

   localparam int WL = 21;
   localparam int FW = WL - 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [31:0]   float_i = '0;
   logic          valid_o;
   logic          ready_i = 1'b0;
   logic          sign_o;
   logic          integer_o;
   logic [FW-1:0] fractional_o;
   logic          sat_o;
   logic          nan_o;

   always #5 clk = ~clk;

   float_to_fixed #(.WORD_LENGTH(WL)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .float_i      (float_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .sign_o       (sign_o),
      .integer_o    (integer_o),
      .fractional_o (fractional_o),
      .sat_o        (sat_o),
      .nan_o        (nan_o)
   );

   typedef struct {
      logic [31:0]   f;
      logic          s;
      logic          i;
      logic [FW-1:0] fr;
      logic          sat;
      logic          nan;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];
   vec_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(input logic [31:0] f, input logic s, input logic i,
                               input logic [FW-1:0] fr, input logic sat, input logic nan);
      vec_t v;
      v.f = f; v.s = s; v.i = i; v.fr = fr; v.sat = sat; v.nan = nan;
      return v;
   endfunction

   task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic chk_res(input vec_t e);
      chk1($sformatf("result %08h {s,i,frac,sat,nan}", e.f),
           32'({sign_o, integer_o, fractional_o, sat_o, nan_o}),
           32'({e.s, e.i, e.fr, e.sat, e.nan}));
   endtask

   // One clock cycle: drive at the falling edge, check outputs against the
   // scoreboard head, then record acceptance for the coming rising edge.
   task automatic cycle(input logic v, input int idx, input logic rdy,
                        input int exp_rdy, output logic acc);
      @(negedge clk);
      valid_i = v;
      float_i = vecs[idx].f;
      ready_i = rdy;
      #1;
      if (exp_rdy >= 0) chk1("ready_o", 32'(ready_o), 32'(exp_rdy));
      if (valid_o) begin
         if (exp_q.size() == 0) begin
            chk1("spurious valid_o", 32'(valid_o), 32'd0);
         end else begin
            chk_res(exp_q[0]);
            if (rdy) void'(exp_q.pop_front());
         end
      end
      acc = v && ready_o;
      if (acc) exp_q.push_back(vecs[idx]);
   endtask

   task automatic drain();
      logic acc;
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) cycle(1'b0, 0, 1'b1, -1, acc);
      chk1("drain queue empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_zero_outputs(input string name);
      chk1({name, " valid_o"}, 32'(valid_o), 32'd0);
      chk1({name, " outputs"},
           32'({sign_o, integer_o, fractional_o, sat_o, nan_o}), 32'd0);
      chk1({name, " ready_o"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      logic acc;
      int   budget;

      vecs[0]  = mk(32'h3F800000, 1'b0, 1'b1, 19'h00000, 1'b0, 1'b0); // 1.0
      vecs[1]  = mk(32'hBF000000, 1'b1, 1'b0, 19'h40000, 1'b0, 1'b0); // -0.5
      vecs[2]  = mk(32'h3F490FDB, 1'b0, 1'b0, 19'h6487E, 1'b0, 1'b0); // pi/4
      vecs[3]  = mk(32'h40400000, 1'b0, 1'b1, 19'h7FFFF, 1'b1, 1'b0); // 3.0
      vecs[4]  = mk(32'hFF800000, 1'b1, 1'b1, 19'h7FFFF, 1'b1, 1'b0); // -inf
      vecs[5]  = mk(32'h7FC00000, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b1); // NaN
      vecs[6]  = mk(32'h80000000, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0); // -0.0
      vecs[7]  = mk(32'h35800000, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0); // 2^-20
      vecs[8]  = mk(32'hB5800000, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0); // -2^-20
      vecs[9]  = mk(32'h36000000, 1'b0, 1'b0, 19'h00001, 1'b0, 1'b0); // 2^-19
      vecs[10] = mk(32'hB6000000, 1'b1, 1'b0, 19'h00001, 1'b0, 1'b0); // -2^-19
      vecs[11] = mk(32'h80000001, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0); // -subnormal
      vecs[12] = mk(32'h7F800000, 1'b0, 1'b1, 19'h7FFFF, 1'b1, 1'b0); // +inf
      vecs[13] = mk(32'h7F7FFFFF, 1'b0, 1'b1, 19'h7FFFF, 1'b1, 1'b0); // max normal
      vecs[14] = mk(32'h3FC00000, 1'b0, 1'b1, 19'h40000, 1'b0, 1'b0); // 1.5
      vecs[15] = mk(32'hBFE00000, 1'b1, 1'b1, 19'h60000, 1'b0, 1'b0); // -1.75
      vecs[16] = mk(32'h3FFFFFFF, 1'b0, 1'b1, 19'h7FFFF, 1'b0, 1'b0); // just below 2
      vecs[17] = mk(32'hFFC00001, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b1); // -NaN
      vecs[18] = mk(32'hC0000000, 1'b1, 1'b1, 19'h7FFFF, 1'b1, 1'b0); // -2.0
      vecs[19] = mk(32'h3F7FFFFF, 1'b0, 1'b0, 19'h7FFFF, 1'b0, 1'b0); // just below 1

      // Reset state
      rst = 1'b0;
      #12;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b1;

      // Two-cycle latency with ready_i held high
      cycle(1'b1, 0, 1'b1, 1, acc);
      cycle(1'b0, 0, 1'b1, 1, acc);
      chk1("latency after 1 edge valid_o", 32'(valid_o), 32'd0);
      cycle(1'b0, 0, 1'b1, 1, acc);
      chk1("latency after 2 edges valid_o", 32'(valid_o), 32'd1);
      drain();

      // Full-rate stream of every vector
      for (int i = 0; i < NV; i++) cycle(1'b1, i, 1'b1, 1, acc);
      drain();

      // Backpressure: 1.0, -0.5 held, 3.0 waits until ready_i rises
      cycle(1'b1, 0, 1'b0, 1, acc);
      cycle(1'b1, 1, 1'b0, 1, acc);
      cycle(1'b1, 3, 1'b0, 0, acc);
      cycle(1'b1, 3, 1'b0, 0, acc);
      cycle(1'b1, 3, 1'b1, 1, acc);
      chk1("stalled operand accepted", 32'(acc), 32'd1);
      drain();

      // Random backpressure and gaps
      budget = 2000;
      for (int i = 0; i < NV; i++) begin
         if ($urandom_range(0, 3) == 0) cycle(1'b0, 0, 1'($urandom_range(0, 1)), -1, acc);
         acc = 1'b0;
         while (!acc && budget > 0) begin
            cycle(1'b1, i, 1'($urandom_range(0, 1)), -1, acc);
            budget--;
         end
      end
      chk1("random phase within budget", 32'(budget > 0), 32'd1);
      drain();

      // Reset with two operands in flight
      cycle(1'b1, 0, 1'b1, 1, acc);
      cycle(1'b1, 1, 1'b1, 1, acc);
      @(negedge clk);
      valid_i = 1'b0;
      rst = 1'b0;
      #1;
      chk_zero_outputs("mid-flight reset");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 0, 1'b1, 1, acc);
         chk1("no stale result after reset", 32'(valid_o), 32'd0);
      end
      cycle(1'b1, 4, 1'b1, 1, acc);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
